// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA encrypt/decrypt datapaths: default operand
// width, controller state encoding and the per-operation latency helper.
package rsa_pkg;

  localparam int RSA_W = 128;

  // One modular product costs go cycle + W iterations + hand-back cycle.
  localparam int RSA_OP_CYCLES = RSA_W + 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REDUCE = 3'd1,
    ST_SQ     = 3'd2,
    ST_MUL    = 3'd3,
    ST_FINISH = 3'd4
  } dec_state_e;

  function automatic int opCycles(input int w);
    return w + 2;
  endfunction

endpackage

// File: rtl/rsa_mod_mult.sv
// Bit-serial interleaved modular multiplier: r = a*b mod n, one bit of b per
// clock, MSB first. Requires a < n so the W+1 bit intermediates never overflow.
// A go pulse latches the operands; mod_done pulses W+1 cycles later with r valid.
module rsa_mod_mult
  import rsa_pkg::*;
#(
  parameter int W = RSA_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         go,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] n,
  output logic [W-1:0] r,
  output logic         mod_done
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  logic [W-1:0]  a_q, b_q, n_q, r_q, r_d;
  logic [CW-1:0] cnt_q;
  logic          active_q, done_q;

  logic [W:0] nExt, dbl, dblRed, acc;

  // One Horner step: double and reduce, then conditionally add a and reduce.
  always_comb begin
    nExt   = {1'b0, n_q};
    dbl    = {r_q, 1'b0};
    dblRed = (dbl >= nExt) ? (dbl - nExt) : dbl;
    acc    = dblRed + (b_q[cnt_q] ? {1'b0, a_q} : '0);
    r_d    = (acc >= nExt) ? W'(acc - nExt) : W'(acc);
  end

  // Operand capture on go, then W iteration cycles ending with a done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q      <= '0;
      b_q      <= '0;
      n_q      <= '0;
      r_q      <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (go) begin
        a_q      <= a;
        b_q      <= b;
        n_q      <= n;
        r_q      <= '0;
        cnt_q    <= CW'(W - 1);
        active_q <= 1'b1;
      end else if (active_q) begin
        r_q <= r_d;
        if (cnt_q == '0) begin
          active_q <= 1'b0;
          done_q   <= 1'b1;
        end else begin
          cnt_q <= cnt_q - CW'(1);
        end
      end
    end
  end

  assign r        = r_q;
  assign mod_done = done_q;

endmodule

// File: rtl/top_level_dec.sv
// RSA decryption top level: message = c^d_key mod n by left-to-right
// square-and-multiply, every product done by one shared rsa_mod_mult.
// Optional build macro DEC_LEADING_ZERO_SKIP_EN: leading zero exponent bits are
// consumed one per cycle without a squaring (result is unchanged either way).
module top_level_dec
  import rsa_pkg::*;
#(
  parameter int W = RSA_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] c,
  input  logic [W-1:0] d_key,
  input  logic [W-1:0] n,
  output logic [W-1:0] message,
  output logic         busy,
  output logic         done
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  dec_state_e    state_q, state_d;
  logic          issued_q, issued_d;
  logic [W-1:0]  c_q, c_d, exp_q, exp_d, n_q, n_d;
  logic [W-1:0]  base_q, base_d, result_q, result_d, message_q, message_d;
  logic [CW-1:0] bitCnt_q, bitCnt_d;
  logic          busy_q, busy_d, done_q, done_d;
`ifdef DEC_LEADING_ZERO_SKIP_EN
  logic          lead_q, lead_d;
`endif

  logic          multGo, multDone, advance;
  logic [W-1:0]  multA, multB, multR;

  rsa_mod_mult #(.W(W)) uMult (
    .clk      (clk),
    .reset    (reset),
    .go       (multGo),
    .a        (multA),
    .b        (multB),
    .n        (n_q),
    .r        (multR),
    .mod_done (multDone)
  );

  // Controller: dispatch one product per state entry, absorb its result, then
  // step to the next exponent bit or finish.
  always_comb begin
    state_d   = state_q;
    issued_d  = issued_q;
    c_d       = c_q;
    exp_d     = exp_q;
    n_d       = n_q;
    base_d    = base_q;
    result_d  = result_q;
    bitCnt_d  = bitCnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    message_d = message_q;
    multGo    = 1'b0;
    multA     = result_q;
    multB     = result_q;
    advance   = 1'b0;
`ifdef DEC_LEADING_ZERO_SKIP_EN
    lead_d    = lead_q;
`endif

    if (done_q) begin
      busy_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (start && !busy_q) begin
          c_d      = c;
          exp_d    = d_key;
          n_d      = n;
          busy_d   = 1'b1;
          issued_d = 1'b0;
          bitCnt_d = CW'(W - 1);
`ifdef DEC_LEADING_ZERO_SKIP_EN
          lead_d   = 1'b1;
`endif
          if (n < W'(2)) begin
            result_d = '0;
            state_d  = ST_FINISH;
          end else begin
            state_d = ST_REDUCE;
          end
        end
      end

      ST_REDUCE: begin
        multA = W'(1);
        multB = c_q;
        if (!issued_q) begin
          multGo   = 1'b1;
          issued_d = 1'b1;
        end else if (multDone) begin
          base_d   = multR;
          result_d = W'(1);
          issued_d = 1'b0;
          state_d  = ST_SQ;
        end
      end

      ST_SQ: begin
        if (!issued_q) begin
`ifdef DEC_LEADING_ZERO_SKIP_EN
          if (lead_q && !exp_q[W-1]) begin
            advance = 1'b1;
          end else begin
            lead_d   = 1'b0;
            multGo   = 1'b1;
            issued_d = 1'b1;
          end
`else
          multGo   = 1'b1;
          issued_d = 1'b1;
`endif
        end else if (multDone) begin
          result_d = multR;
          issued_d = 1'b0;
          if (exp_q[W-1]) begin
            state_d = ST_MUL;
          end else begin
            advance = 1'b1;
          end
        end
      end

      ST_MUL: begin
        multB = base_q;
        if (!issued_q) begin
          multGo   = 1'b1;
          issued_d = 1'b1;
        end else if (multDone) begin
          result_d = multR;
          issued_d = 1'b0;
          advance  = 1'b1;
        end
      end

      ST_FINISH: begin
        message_d = result_q;
        done_d    = 1'b1;
        issued_d  = 1'b0;
        state_d   = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (advance) begin
      exp_d = {exp_q[W-2:0], 1'b0};
      if (bitCnt_q == '0) begin
        state_d = ST_FINISH;
      end else begin
        bitCnt_d = bitCnt_q - CW'(1);
        state_d  = ST_SQ;
      end
    end
  end

  // State, operand and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      issued_q  <= 1'b0;
      c_q       <= '0;
      exp_q     <= '0;
      n_q       <= '0;
      base_q    <= '0;
      result_q  <= '0;
      bitCnt_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      message_q <= '0;
`ifdef DEC_LEADING_ZERO_SKIP_EN
      lead_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      issued_q  <= issued_d;
      c_q       <= c_d;
      exp_q     <= exp_d;
      n_q       <= n_d;
      base_q    <= base_d;
      result_q  <= result_d;
      bitCnt_q  <= bitCnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      message_q <= message_d;
`ifdef DEC_LEADING_ZERO_SKIP_EN
      lead_q    <= lead_d;
`endif
    end
  end

  assign message = message_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_top_level_dec.sv
// Self-checking bench for top_level_dec: table vectors, handshake corner
// cases and random operands against a plain-arithmetic modexp model.
module tb_top_level_dec;
  import rsa_pkg::*;

  localparam int WS = 8;
  localparam int WL = 128;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          startS, busyS, doneS;
  logic [WS-1:0] cS, dS, nS, msgS;
  logic          startL, busyL, doneL;
  logic [WL-1:0] cL, dL, nL, msgL;

  top_level_dec #(.W(WS)) dutS (
    .clk(clk), .reset(reset), .start(startS), .c(cS), .d_key(dS), .n(nS),
    .message(msgS), .busy(busyS), .done(doneS)
  );

  top_level_dec #(.W(WL)) dutL (
    .clk(clk), .reset(reset), .start(startL), .c(cL), .d_key(dL), .n(nL),
    .message(msgL), .busy(busyL), .done(doneL)
  );

  int vecCount  = 0;
  int missCount = 0;

  typedef struct {
    logic [WS-1:0] c;
    logic [WS-1:0] d;
    logic [WS-1:0] n;
    logic [WS-1:0] expMsg;
    int            expN;
  } vec_t;

  vec_t vecs[4];

  task automatic checkOutput(input string name, input logic [WL-1:0] actual,
                             input logic [WL-1:0] expected);
    vecCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // c^d mod n by repeated multiplication (n < 2^8 so 64-bit products suffice).
  function automatic logic [WS-1:0] refModExp(input int cv, input int dv, input int nv);
    longint unsigned r, b;
    if (nv < 2) return '0;
    r = 1;
    b = longint'(cv) % longint'(nv);
    for (int i = 0; i < dv; i++) r = (r * b) % longint'(nv);
    return WS'(r);
  endfunction

  // Cycles from the start-sampling edge to the done pulse.
  function automatic int refLatency(input logic [WL-1:0] dv, input int nv, input int w);
    int lz, k, sq, extra;
    if (nv < 2) return 1;
    lz = 0;
    for (int i = w - 1; i >= 0; i--) begin
      if (dv[i]) break;
      lz++;
    end
    k = $countones(dv);
`ifdef DEC_LEADING_ZERO_SKIP_EN
    sq = w - lz;
    extra = lz;
`else
    sq = w;
    extra = 0;
`endif
    return 1 + opCycles(w) * (1 + sq + k) + extra;
  endfunction

  // Called #1 after an edge: start is sampled on the next edge. A second start
  // with other operands is pulsed when the cycle count reaches injectAt.
  task automatic applyStimulus(input logic [WS-1:0] cv, input logic [WS-1:0] dv,
                               input logic [WS-1:0] nv, input int injectAt,
                               output int cycles, output logic busyAfterStart,
                               output logic timedOut);
    startS = 1'b1;
    cS = cv;
    dS = dv;
    nS = nv;
    @(posedge clk);
    #1;
    startS = 1'b0;
    cS = WS'($urandom);
    dS = WS'($urandom);
    nS = WS'($urandom);
    busyAfterStart = busyS;
    cycles = 0;
    while (doneS !== 1'b1 && cycles < 2000) begin
      if (cycles == injectAt) begin
        startS = 1'b1;
        cS = 8'd50;
        dS = 8'd5;
        nS = 8'd200;
      end else begin
        startS = 1'b0;
      end
      @(posedge clk);
      #1;
      cycles++;
    end
    startS = 1'b0;
    timedOut = (doneS !== 1'b1);
  endtask

  task automatic runVector(input string name, input logic [WS-1:0] cv,
                           input logic [WS-1:0] dv, input logic [WS-1:0] nv,
                           input logic [WS-1:0] expMsg, input int expN,
                           input int injectAt);
    int   cycles;
    logic busyAfterStart, timedOut;
    applyStimulus(cv, dv, nv, injectAt, cycles, busyAfterStart, timedOut);
    checkOutput({name, ".busyAfterStart"}, WL'(busyAfterStart), WL'(1));
    checkOutput({name, ".timeout"}, WL'(timedOut), WL'(0));
    checkOutput({name, ".message"}, WL'(msgS), WL'(expMsg));
    checkOutput({name, ".latency"}, WL'(cycles), WL'(expN));
    @(posedge clk);
    #1;
    checkOutput({name, ".doneOneCycle"}, WL'(doneS), WL'(0));
    checkOutput({name, ".busyAfterDone"}, WL'(busyS), WL'(0));
  endtask

  initial begin
    int   cycles, seenDone;
    logic [WS-1:0] rc, rd, rn;

`ifdef DEC_LEADING_ZERO_SKIP_EN
    vecs[0] = '{c: 8'd11,  d: 8'd23, n: 8'd187, expMsg: 8'd88, expN: 104};
    vecs[1] = '{c: 8'd198, d: 8'd23, n: 8'd187, expMsg: 8'd88, expN: 104};
    vecs[2] = '{c: 8'd50,  d: 8'd0,  n: 8'd187, expMsg: 8'd1,  expN: 19};
`else
    vecs[0] = '{c: 8'd11,  d: 8'd23, n: 8'd187, expMsg: 8'd88, expN: 131};
    vecs[1] = '{c: 8'd198, d: 8'd23, n: 8'd187, expMsg: 8'd88, expN: 131};
    vecs[2] = '{c: 8'd50,  d: 8'd0,  n: 8'd187, expMsg: 8'd1,  expN: 91};
`endif
    vecs[3] = '{c: 8'd77,  d: 8'd23, n: 8'd1,   expMsg: 8'd0,  expN: 1};

    reset = 1'b1;
    startS = 1'b0; cS = '0; dS = '0; nS = '0;
    startL = 1'b0; cL = '0; dL = '0; nL = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset.message", WL'(msgS), WL'(0));
    checkOutput("reset.busy", WL'(busyS), WL'(0));
    checkOutput("reset.done", WL'(doneS), WL'(0));
    reset = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 4; i++) begin
      runVector($sformatf("table%0d", i), vecs[i].c, vecs[i].d, vecs[i].n,
                vecs[i].expMsg, vecs[i].expN, -1);
    end

    // Wide operands: textbook 3233 key.
    startL = 1'b1;
    cL = WL'(2790);
    dL = WL'(2753);
    nL = WL'(3233);
    @(posedge clk);
    #1;
    startL = 1'b0;
    cycles = 0;
    while (doneL !== 1'b1 && cycles < 20000) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    checkOutput("wide.timeout", WL'(doneL !== 1'b1), WL'(0));
    checkOutput("wide.message", msgL, WL'(65));
    checkOutput("wide.latency", WL'(cycles), WL'(refLatency(WL'(2753), 3233, WL)));
    @(posedge clk);
    #1;
    checkOutput("wide.doneOneCycle", WL'(doneL), WL'(0));
    checkOutput("wide.busyAfterDone", WL'(busyL), WL'(0));

    // Start during a run is ignored; start right after done is accepted.
    runVector("midStart", 8'd11, 8'd23, 8'd187, 8'd88,
              refLatency(WL'(23), 187, WS), 20);
    runVector("backToBack", 8'd2, 8'd7, 8'd187, refModExp(2, 7, 187),
              refLatency(WL'(7), 187, WS), -1);

    for (int i = 0; i < 40; i++) begin
      rn = WS'($urandom_range(2, 255));
      rc = WS'($urandom_range(0, 255));
      rd = WS'($urandom_range(0, 255));
      runVector($sformatf("rand%0d", i), rc, rd, rn,
                refModExp(int'(rc), int'(rd), int'(rn)),
                refLatency(WL'(rd), int'(rn), WS), -1);
    end

    // Reset 40 cycles into a run aborts it without a done pulse.
    startS = 1'b1;
    cS = 8'd11;
    dS = 8'd23;
    nS = 8'd187;
    @(posedge clk);
    #1;
    startS = 1'b0;
    repeat (39) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("abort.busy", WL'(busyS), WL'(0));
    checkOutput("abort.done", WL'(doneS), WL'(0));
    checkOutput("abort.message", WL'(msgS), WL'(0));
    seenDone = 0;
    repeat (200) begin
      @(posedge clk);
      #1;
      if (doneS === 1'b1) seenDone++;
    end
    checkOutput("abort.noLateDone", WL'(seenDone), WL'(0));
    runVector("afterAbort", 8'd198, 8'd23, 8'd187, 8'd88,
              refLatency(WL'(23), 187, WS), -1);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule

// File: doc/top_level_dec.md
# top_level_dec

RSA decryption top level: computes message = c^d mod n by left-to-right square-and-multiply. It is the receive-side counterpart of the encryption top level and shares its start/done handshake and operand widths. Every modular product uses one bit-serial interleaved modular multiplier, so no double-width product and no divider are needed. Results are bit-exact with the encryption path, so encrypt→decrypt round trips are checked end to end.

## Interface
- W, 128, operand/modulus width in bits (≥4)
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; one clock, reset synchronous active-high
- start  in  1  one-cycle request; sampled only when busy=0
- c  in  W  ciphertext; any value, need not be < n
- d_key  in  W  private exponent
- n  in  W  modulus
- message  out  W  result; reset 0; holds until next accepted start
- busy  out  1  reset 0; high from cycle after accepted start through done cycle
- done  out  1  reset 0; single-cycle pulse when message valid

## Operation
- Accepted start captures c, d_key, n into internal registers; later input changes ignored.
- start while busy=1 is ignored. start coincident with reset: reset wins.
- States: IDLE → REDUCE → SQ ⇄ MUL → FINISH → IDLE.
- IDLE: on start, if n<2 → FINISH with message=0; else → REDUCE.
- REDUCE: base = mod_mult(a=1, b=c) = c mod n (Horner reduction, valid for any c).
- Then result=1 and exponent bits are scanned MSB first: SQ computes result = result·result mod n; if the current bit is 1, MUL computes result = result·base mod n; shift exponent, decrement bit counter.
- After bit 0 → FINISH: message=result, done=1, busy=0 → IDLE.
- d_key=0 → message=1 (n≥2).
- mod_mult: r=0; for i=W-1..0: r=2r, if r≥n r-=n; if b[i] r+=a, if r≥n r-=n. Intermediates are W+1 bits wide and never overflow because a<n is guaranteed (a is 1, base or result).
- Reset mid-operation: back to IDLE next cycle, all outputs 0, multiplier aborted; no done pulse.

## Timing
- Multiplier handshake: go pulse in a dispatch cycle; mod_done pulses exactly W+1 cycles later with r valid. The controller latches r on that edge and dispatches the next operation in the following cycle, so each operation costs W+2 cycles.
- ops = 1 (REDUCE) + squarings + k, where k = popcount(d_key) and squarings = W (skip disabled).
- done is high exactly N = 1 + (W+2)·ops cycles after the edge that sampled start. For n<2, N = 1.
- Back-to-back: start may be asserted in the cycle after done.

## Configuration
- DEC_LEADING_ZERO_SKIP_EN defined: leading zero bits of d_key are consumed in one cycle each with no multiplier operation; squarings = W − lz, where lz = leading-zero count. For d_key=0 the controller goes straight from REDUCE to FINISH (ops=1, but the lz consume cycles still elapse: N = 1 + (W+2) + W).
- Undefined: all W bits get a squaring. Latency depends only on W and k.
- message value is identical in both builds.

## Structure
- Shared package rsa_pkg: state encoding constants, default width RSA_W=128, and the latency helper constant (W+2).
- One sub-module rsa_mod_mult (clk, reset, go, a, b, n, r, mod_done). It is reused later by the encryption path.
- Controller, operand registers and exponent shift register stay in top_level_dec.

## Test plan
- W=8, n=187, d_key=23, c=11 → message=88. Skip off: done at N=131. Skip on: N=1+10·10+3=104.
- W=128, n=3233, d_key=2753, c=2790 → message=65, one done pulse, busy low afterwards.
- W=8, n=187, d_key=23, c=198 (≥n) → message=88 (REDUCE path).
- W=8, d_key=0, n=187, c=50 → message=1. n=1 → message=0 with done at N=1.
- Assert start again mid-run with different c → ignored, original result returned. Then start in the cycle after done → accepted.
- Reset 40 cycles into a run → next cycle busy=0, done=0, message=0, no later done pulse. A fresh start then decrypts correctly.
